// File: rtl/wring_pkg.sv
// rtl/wring_pkg.sv - shared types and default sizes for the weight ring buffer
package wring_pkg;

  localparam int WRING_DW  = 8;
  localparam int WRING_K_H = 3;
  localparam int WRING_K_W = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } shadow_state_e;

endpackage

// File: rtl/wring_bank.sv
// rtl/wring_bank.sv - one K_H x K_W weight bank: column write, left rotate, col0/last taps
module wring_bank
  import wring_pkg::*;
#(
  parameter int DW  = WRING_DW,
  parameter int K_H = WRING_K_H,
  parameter int K_W = WRING_K_W,
  parameter int CW  = $clog2(K_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_col,
  input  logic [K_H*DW-1:0] wr_data,
  input  logic              rot,
  output logic [K_H*DW-1:0] col0,
  output logic [K_H*DW-1:0] col_last
);

  // Each entry is a whole column beat, so rotating entries rotates every row at once.
  logic [K_H*DW-1:0] mem [K_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < K_W; j++) mem[j] <= '0;
    end else if (clear) begin
      for (int j = 0; j < K_W; j++) mem[j] <= '0;
    end else if (wr_en) begin
      mem[wr_col] <= wr_data;
    end else if (rot) begin
      for (int j = 0; j < K_W; j++) mem[j] <= mem[(j + 1) % K_W];
    end
  end

  assign col0     = mem[0];
  assign col_last = mem[K_W-1];

endmodule

// File: rtl/weight_ring_buf.sv
// rtl/weight_ring_buf.sv - ping-pong rotating weight register; WRING_TAP_LAST_EN adds out_tap_last
module weight_ring_buf
  import wring_pkg::*;
#(
  parameter int DW  = WRING_DW,
  parameter int K_H = WRING_K_H,
  parameter int K_W = WRING_K_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [K_H*DW-1:0]        in_data,
  input  logic                     shift,
  input  logic                     swap,
  output logic                     swap_ack,
  output logic [K_H*DW-1:0]        out_data,
  output logic                     active_valid,
  output logic                     shadow_full,
  output logic [$clog2(K_W)-1:0]   rot_cnt
`ifdef WRING_TAP_LAST_EN
  ,
  output logic [K_H*DW-1:0]        out_tap_last
`endif
);

  localparam int CW = $clog2(K_W);
  localparam logic [CW-1:0] LAST_COL = CW'(K_W - 1);

  shadow_state_e state, state_nxt;
  logic          bank_sel;   // index of the active bank; the other one is shadow
  logic [CW-1:0] wr_col;
  logic          accept, swap_take, shift_take;
  logic [K_H*DW-1:0] col0_a, col0_b, last_a, last_b;

  assign shadow_full = (state == FULL);
  assign in_ready    = !shadow_full;
  assign accept      = in_valid && in_ready;
  // Swap only lands at rotation origin so the PE row never sees a partial kernel.
  assign swap_take   = swap && shadow_full && ((rot_cnt == '0) || !active_valid);
  assign shift_take  = shift && active_valid && !swap_take;
  assign swap_ack    = swap_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= EMPTY;
    else if (clear) state <= EMPTY;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FILLING;
      FILLING: if (accept && wr_col == LAST_COL) state_nxt = FULL;
      FULL:    if (swap_take) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel     <= 1'b0;
      active_valid <= 1'b0;
      rot_cnt      <= '0;
      wr_col       <= '0;
    end else if (clear) begin
      bank_sel     <= 1'b0;
      active_valid <= 1'b0;
      rot_cnt      <= '0;
      wr_col       <= '0;
    end else begin
      if (swap_take) begin
        bank_sel     <= !bank_sel;
        active_valid <= 1'b1;
        rot_cnt      <= '0;
        wr_col       <= '0;
      end else begin
        if (shift_take) rot_cnt <= (rot_cnt == LAST_COL) ? '0 : rot_cnt + 1'b1;
        if (accept)     wr_col  <= (wr_col == LAST_COL) ? '0 : wr_col + 1'b1;
      end
    end
  end

  wring_bank #(.DW(DW), .K_H(K_H), .K_W(K_W), .CW(CW)) u_bank_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_en    (accept && bank_sel),
    .wr_col   (wr_col),
    .wr_data  (in_data),
    .rot      (shift_take && !bank_sel),
    .col0     (col0_a),
    .col_last (last_a)
  );

  wring_bank #(.DW(DW), .K_H(K_H), .K_W(K_W), .CW(CW)) u_bank_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_en    (accept && !bank_sel),
    .wr_col   (wr_col),
    .wr_data  (in_data),
    .rot      (shift_take && bank_sel),
    .col0     (col0_b),
    .col_last (last_b)
  );

  assign out_data = bank_sel ? col0_b : col0_a;

`ifdef WRING_TAP_LAST_EN
  assign out_tap_last = bank_sel ? last_b : last_a;
`else
  logic unused_last;
  assign unused_last = ^{last_a, last_b};
`endif

endmodule

// File: tb/tb_weight_ring_buf.sv
// tb/tb_weight_ring_buf.sv - directed self-checking bench for weight_ring_buf
module tb_weight_ring_buf;

  localparam int DW  = 8;
  localparam int K_H = 3;
  localparam int K_W = 3;

  logic              clk = 1'b0;
  logic              rst_n, clear, in_valid, in_ready, shift, swap, swap_ack;
  logic              active_valid, shadow_full;
  logic [K_H*DW-1:0] in_data, out_data;
  logic [1:0]        rot_cnt;
`ifdef WRING_TAP_LAST_EN
  logic [K_H*DW-1:0] out_tap_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_ring_buf #(.DW(DW), .K_H(K_H), .K_W(K_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .shift        (shift),
    .swap         (swap),
    .swap_ack     (swap_ack),
    .out_data     (out_data),
    .active_valid (active_valid),
    .shadow_full  (shadow_full),
    .rot_cnt      (rot_cnt)
`ifdef WRING_TAP_LAST_EN
    ,
    .out_tap_last (out_tap_last)
`endif
  );

  function automatic logic [K_H*DW-1:0] bt(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; shift = 1'b0; swap = 1'b0;
    tick(); tick();
    chk("rst_out", 32'(out_data), 32'(0));
    chk("rst_av", 32'(active_valid), 32'(0));
    chk("rst_full", 32'(shadow_full), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    chk("rst_ack", 32'(swap_ack), 32'(0));
    chk("rst_rot", 32'(rot_cnt), 32'(0));
    rst_n = 1'b1;
    tick();

    // T1 fill
    in_valid = 1'b1;
    in_data = bt(1, 2, 3); tick();
    in_data = bt(4, 5, 6); tick();
    in_data = bt(7, 8, 9); tick();
    chk("t1_full", 32'(shadow_full), 32'(1));
    chk("t1_ready", 32'(in_ready), 32'(0));
    chk("t1_av", 32'(active_valid), 32'(0));
    chk("t1_out", 32'(out_data), 32'(0));
    in_data = bt(99, 99, 99); tick();
    in_valid = 1'b0;

    // T2 swap + rotate
    swap = 1'b1; #1;
    chk("t2_ack", 32'(swap_ack), 32'(1));
    tick();
    chk("t2_ack_once", 32'(swap_ack), 32'(0));
    swap = 1'b0;
    chk("t2_out0", 32'(out_data), 32'(bt(1, 2, 3)));
    chk("t2_av", 32'(active_valid), 32'(1));
    chk("t2_full", 32'(shadow_full), 32'(0));
    chk("t2_ready", 32'(in_ready), 32'(1));
    chk("t2_rot0", 32'(rot_cnt), 32'(0));
`ifdef WRING_TAP_LAST_EN
    chk("t2_tap", 32'(out_tap_last), 32'(bt(7, 8, 9)));
`endif
    shift = 1'b1;
    tick(); chk("t2_out1", 32'(out_data), 32'(bt(4, 5, 6))); chk("t2_rot1", 32'(rot_cnt), 32'(1));
    tick(); chk("t2_out2", 32'(out_data), 32'(bt(7, 8, 9))); chk("t2_rot2", 32'(rot_cnt), 32'(2));
    tick(); chk("t2_out3", 32'(out_data), 32'(bt(1, 2, 3))); chk("t2_rot3", 32'(rot_cnt), 32'(0));

    // T4 load kernel B while A keeps rotating
    in_valid = 1'b1;
    in_data = bt(10, 11, 12); tick(); chk("t4_out1", 32'(out_data), 32'(bt(4, 5, 6)));
    in_data = bt(13, 14, 15); tick(); chk("t4_out2", 32'(out_data), 32'(bt(7, 8, 9)));
    in_data = bt(16, 17, 18); tick(); chk("t4_out3", 32'(out_data), 32'(bt(1, 2, 3)));
    chk("t4_rot", 32'(rot_cnt), 32'(0));
    chk("t4_full", 32'(shadow_full), 32'(1));
    in_valid = 1'b0;

    // T3 swap held off until rotation returns to origin
    tick(); chk("t3_rot1", 32'(rot_cnt), 32'(1));
    shift = 1'b0; swap = 1'b1; #1;
    chk("t3_noack_a", 32'(swap_ack), 32'(0));
    tick(); chk("t3_hold", 32'(out_data), 32'(bt(4, 5, 6)));
    shift = 1'b1; #1;
    chk("t3_noack_b", 32'(swap_ack), 32'(0));
    tick(); chk("t3_rot2", 32'(rot_cnt), 32'(2));
    #1; chk("t3_noack_c", 32'(swap_ack), 32'(0));
    tick(); chk("t3_rot0", 32'(rot_cnt), 32'(0));
    chk("t3_out", 32'(out_data), 32'(bt(1, 2, 3)));

    // T5 swap + shift together at origin: swap wins
    #1; chk("t5_ack", 32'(swap_ack), 32'(1));
    tick();
    swap = 1'b0; shift = 1'b0;
    chk("t5_out", 32'(out_data), 32'(bt(10, 11, 12)));
    chk("t5_rot", 32'(rot_cnt), 32'(0));
    chk("t5_full", 32'(shadow_full), 32'(0));
    shift = 1'b1; tick(); shift = 1'b0;
    chk("t5_out1", 32'(out_data), 32'(bt(13, 14, 15)));
    chk("t5_rot1", 32'(rot_cnt), 32'(1));

    // T6 clear mid-fill, refill, then async reset mid-rotation
    in_valid = 1'b1; in_data = bt(50, 51, 52); tick(); in_valid = 1'b0;
    chk("t6_partial", 32'(shadow_full), 32'(0));
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t6_clr_out", 32'(out_data), 32'(0));
    chk("t6_clr_av", 32'(active_valid), 32'(0));
    chk("t6_clr_rot", 32'(rot_cnt), 32'(0));
    chk("t6_clr_ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    in_data = bt(20, 21, 22); tick();
    in_data = bt(23, 24, 25); tick();
    in_data = bt(26, 27, 28); tick();
    in_valid = 1'b0;
    chk("t6_full", 32'(shadow_full), 32'(1));
    swap = 1'b1; #1;
    chk("t6_ack", 32'(swap_ack), 32'(1));
    tick(); swap = 1'b0;
    chk("t6_out0", 32'(out_data), 32'(bt(20, 21, 22)));
    shift = 1'b1; tick(); shift = 1'b0;
    chk("t6_out1", 32'(out_data), 32'(bt(23, 24, 25)));
`ifdef WRING_TAP_LAST_EN
    chk("t6_tap", 32'(out_tap_last), 32'(bt(20, 21, 22)));
`endif
    #2 rst_n = 1'b0; #1;
    chk("t6_rst_out", 32'(out_data), 32'(0));
    chk("t6_rst_av", 32'(active_valid), 32'(0));
    chk("t6_rst_rot", 32'(rot_cnt), 32'(0));
    chk("t6_rst_ready", 32'(in_ready), 32'(1));
    chk("t6_rst_full", 32'(shadow_full), 32'(0));
    tick(); rst_n = 1'b1; tick();
    chk("t6_post_out", 32'(out_data), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
